controle_multiciclo: RTL

//  Multicycle control FSM directly upstream of the 16-bit ALU. Decodes the instruction register,

---
 rtl/controle_multiciclo_if.sv | 32 +++
 rtl/controle_multiciclo.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_multiciclo_if.sv
// rtl/controle_multiciclo_if.sv - memory handshake bundle between the multicycle control and the shared memory
//
// Signals:
//   memReq    controller -> memory  access request, held until memReady
//   memWrite  controller -> memory  write qualifier, meaningful only with memReq
//   iorD      controller -> memory  address select: 0 = PC, 1 = ALUOut
//   memReady  memory -> controller  current access completes this cycle
//
// Modports:
//   master  control FSM side
//   slave   memory side

interface controle_multiciclo_if;
  logic memReq;
  logic memWrite;
  logic iorD;
  logic memReady;

  modport master (
    output memReq,
    output memWrite,
    output iorD,
    input  memReady
  );

  modport slave (
    input  memReq,
    input  memWrite,
    input  iorD,
    output memReady
  );
endinterface

// File: rtl/controle_multiciclo.sv
// rtl/controle_multiciclo.sv - multicycle control FSM driving the 16-bit ALU datapath and memory handshake
//
// Sequences fetch / decode / execute / memory / writeback for one instruction at a time.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   instr      in   IR: [15:12] op, [11:9] rs, [8:6] rt, [5:3] rd, [2:0] funct, [5:0] imm
//   zero       in   ALU result == 0, sampled in BRANCH
//   mem_bus    master modport: memReq / memWrite / iorD out, memReady in
//   aluSelect  out  ALU op (000 add .. 111 cmp)
//   aluSrcA    out  0 = PC, 1 = reg A
//   aluSrcB    out  00 = reg B, 01 = const 1, 10 = sign-ext imm
//   irWrite    out  load IR
//   pcWrite    out  load PC
//   pcSrc      out  00 = ALU result, 01 = ALUOut, 10 = jump target
//   regWrite   out  register file write enable
//   regDst     out  0 = rt, 1 = rd
//   memToReg   out  0 = ALUOut, 1 = MDR
//   illegalOp  out  one-cycle pulse on undefined opcode
//   memFault   out  sticky memory timeout
//   halted     out  sticky HALT

module controle_multiciclo #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [15:0]             instr,
  input  logic                    zero,
  controle_multiciclo_if.master   mem_bus,
  output logic [2:0]              aluSelect,
  output logic                    aluSrcA,
  output logic [1:0]              aluSrcB,
  output logic                    irWrite,
  output logic                    pcWrite,
  output logic [1:0]              pcSrc,
  output logic                    regWrite,
  output logic                    regDst,
  output logic                    memToReg,
  output logic                    illegalOp,
  output logic                    memFault,
  output logic                    halted
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_LW   = 4'b0010;
  localparam logic [3:0] OP_SW   = 4'b0011;
  localparam logic [3:0] OP_BEQ  = 4'b0100;
  localparam logic [3:0] OP_J    = 4'b0101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic [1:0] PCSRC_ALU  = 2'b00;
  localparam logic [1:0] PCSRC_OUT  = 2'b01;
  localparam logic [1:0] PCSRC_JUMP = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_WB_R     = 4'd3,
    S_EXEC_I   = 4'd4,
    S_WB_I     = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_MEM_RD   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_MEM_WR   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_HALT     = 4'd12,
    S_ERROR    = 4'd13
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic [3:0] opcode;
  logic [2:0] funct;
  logic       wait_expired;

  // Raw decoded outputs; the ports are these gated by rst_n.
  logic [2:0] alu_select_c;
  logic       alu_src_a_c;
  logic [1:0] alu_src_b_c;
  logic       mem_req_c;
  logic       mem_write_c;
  logic       ior_d_c;
  logic       ir_write_c;
  logic       pc_write_c;
  logic [1:0] pc_src_c;
  logic       reg_write_c;
  logic       reg_dst_c;
  logic       mem_to_reg_c;
  logic       illegal_op_c;
  logic       mem_fault_c;
  logic       halted_c;

  assign opcode       = instr[15:12];
  assign funct        = instr[2:0];
  assign wait_expired = (wait_cnt_q == CNT_LAST);

  // Register fields are consumed by the datapath, not by the controller.
  logic unused_instr;
  assign unused_instr = &{1'b0, instr[11:3]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    alu_select_c = ALU_ADD;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = SRCB_REG;
    mem_req_c    = 1'b0;
    mem_write_c  = 1'b0;
    ior_d_c      = 1'b0;
    ir_write_c   = 1'b0;
    pc_write_c   = 1'b0;
    pc_src_c     = PCSRC_ALU;
    reg_write_c  = 1'b0;
    reg_dst_c    = 1'b0;
    mem_to_reg_c = 1'b0;
    illegal_op_c = 1'b0;
    mem_fault_c  = 1'b0;
    halted_c     = 1'b0;

    case (state_q)
      S_FETCH: begin
        // ALU computes PC+1 while the instruction word is being read.
        mem_req_c   = 1'b1;
        alu_src_b_c = SRCB_ONE;
        if (mem_bus.memReady) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          state_d    = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      S_DECODE: begin
        // Branch target (PC+1 + imm) is speculatively computed into ALUOut.
        alu_src_b_c = SRCB_IMM;
        case (opcode)
          OP_R:         state_d = S_EXEC_R;
          OP_ADDI:      state_d = S_EXEC_I;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_HALT:      state_d = S_HALT;
          default: begin
            illegal_op_c = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end

      S_EXEC_R: begin
        alu_src_a_c  = 1'b1;
        alu_src_b_c  = SRCB_REG;
        alu_select_c = funct;
        state_d      = S_WB_R;
      end

      S_WB_R: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 1'b1;
        state_d     = S_FETCH;
      end

      S_EXEC_I: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
        state_d     = S_WB_I;
      end

      S_WB_I: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end

      S_MEM_ADDR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = SRCB_IMM;
        state_d     = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end

      S_MEM_RD: begin
        mem_req_c = 1'b1;
        ior_d_c   = 1'b1;
        if (mem_bus.memReady) begin
          state_d = S_WB_MEM;
        end else if (wait_expired) begin
          state_d = S_ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      S_WB_MEM: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = 1'b1;
        state_d      = S_FETCH;
      end

      S_MEM_WR: begin
        mem_req_c   = 1'b1;
        ior_d_c     = 1'b1;
        mem_write_c = 1'b1;
        if (mem_bus.memReady) begin
          state_d = S_FETCH;
        end else if (wait_expired) begin
          state_d = S_ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      S_BRANCH: begin
        alu_src_a_c  = 1'b1;
        alu_src_b_c  = SRCB_REG;
        alu_select_c = ALU_SUB;
        pc_write_c   = zero;
        pc_src_c     = PCSRC_OUT;
        state_d      = S_FETCH;
      end

      S_JUMP: begin
        pc_write_c = 1'b1;
        pc_src_c   = PCSRC_JUMP;
        state_d    = S_FETCH;
      end

      S_HALT: begin
        halted_c = 1'b1;
      end

      S_ERROR: begin
        mem_fault_c = 1'b1;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Every state change starts a fresh wait window for the next request.
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end
  end

  // Gating with rst_n forces all-zero outputs the moment reset asserts,
  // so no request or write enable survives into an aborted access.
  assign aluSelect        = rst_n ? alu_select_c : 3'b000;
  assign aluSrcA          = rst_n & alu_src_a_c;
  assign aluSrcB          = rst_n ? alu_src_b_c : 2'b00;
  assign mem_bus.memReq   = rst_n & mem_req_c;
  assign mem_bus.memWrite = rst_n & mem_write_c;
  assign mem_bus.iorD     = rst_n & ior_d_c;
  assign irWrite          = rst_n & ir_write_c;
  assign pcWrite          = rst_n & pc_write_c;
  assign pcSrc            = rst_n ? pc_src_c : 2'b00;
  assign regWrite         = rst_n & reg_write_c;
  assign regDst           = rst_n & reg_dst_c;
  assign memToReg         = rst_n & mem_to_reg_c;
  assign illegalOp        = rst_n & illegal_op_c;
  assign memFault         = rst_n & mem_fault_c;
  assign halted           = rst_n & halted_c;

endmodule
